// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display chain: segment bit order,
// the canonical hex-digit segment patterns and the receiver state encoding.
// The display driver uses the same pattern constants so both ends agree.
package seg7_pkg;

   // Number of segment lines; bit0 = a ... bit6 = g, active-high.
   localparam int SEG_WIDTH = 7;

   // Bit position of each segment inside a pattern.
   typedef enum int {
      SEG_A_BIT = 0,
      SEG_B_BIT = 1,
      SEG_C_BIT = 2,
      SEG_D_BIT = 3,
      SEG_E_BIT = 4,
      SEG_F_BIT = 5,
      SEG_G_BIT = 6
   } seg_bit_e;

   // Canonical hex-digit patterns.
   localparam logic [SEG_WIDTH-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_WIDTH-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_WIDTH-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_WIDTH-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_WIDTH-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_WIDTH-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_WIDTH-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_WIDTH-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_WIDTH-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_WIDTH-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_WIDTH-1:0] SEG_A     = 7'h77;
   localparam logic [SEG_WIDTH-1:0] SEG_B     = 7'h7C;
   localparam logic [SEG_WIDTH-1:0] SEG_C     = 7'h39;
   localparam logic [SEG_WIDTH-1:0] SEG_D     = 7'h5E;
   localparam logic [SEG_WIDTH-1:0] SEG_E     = 7'h79;
   localparam logic [SEG_WIDTH-1:0] SEG_F     = 7'h71;
   localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h00;

   // Pattern table indexed by digit value (entry n holds the pattern of n).
   localparam logic [15:0][SEG_WIDTH-1:0] SEG_TABLE = {
      SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
      SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
   };

   // Receiver candidate-tracking states.
   typedef enum logic [1:0] {
      EMPTY    = 2'd0,   // nothing accepted since reset
      SETTLING = 2'd1,   // candidate counting towards acceptance
      LOCKED   = 2'd2    // candidate accepted and still present
   } rx_state_e;

   // Digit the driver shows after 'prev' when it counts 0..wrap_at.
   function automatic logic [3:0] next_in_seq(input logic [3:0] prev,
                                             input logic [3:0] wrap_at);
      return (prev == wrap_at) ? 4'd0 : prev + 4'd1;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of a 7-segment pattern back to its hex digit.
// Patterns not in the canonical table (including blank) report valid=0.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [SEG_WIDTH-1:0] pattern,
   output logic [3:0]           digit,
   output logic                 valid
);

   // One comparator per table entry; at most one can hit since the
   // canonical patterns are all distinct.
   logic [15:0] hit;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_match
         assign hit[gi] = (pattern == SEG_TABLE[gi]);
      end
   endgenerate

   // Encode the single hit into a digit value.
   always_comb begin
      digit = 4'd0;
      valid = |hit;
      for (int i = 0; i < 16; i++) begin
         if (hit[i]) begin
            digit = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg7_reader.sv
// Receive side of the 7-segment display chain. Synchronises the segment
// lines, waits for a pattern to be stable for STABLE_CYCLES+1 consecutive
// samples, decodes it and checks that successive digits follow the driver's
// 0..WRAP_AT count sequence.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int WRAP_AT       = 6
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SEG_WIDTH-1:0] seg_in,
   output logic [3:0]           digit,
   output logic                 digit_valid,
   output logic                 digit_strobe,
   output logic                 blank,
   output logic                 pattern_err,
   output logic                 seq_err,
   output logic [7:0]           wrap_count
);

   localparam logic [7:0] CNT_LAST   = 8'(STABLE_CYCLES - 1);
   localparam logic [3:0] WRAP_DIGIT = 4'(WRAP_AT);

   // Synchroniser stages.
   logic [SEG_WIDTH-1:0] s1_reg, s2_reg;

   // Candidate tracking.
   logic [SEG_WIDTH-1:0] cand_reg, cand_next;
   logic [7:0]           cnt_reg, cnt_next;
   rx_state_e            state_reg, state_next;

   // Last accepted pattern; acc_any_reg makes the first accept after reset
   // always count as a change, even when the pattern is 0x00.
   logic [SEG_WIDTH-1:0] acc_pat_reg, acc_pat_next;
   logic                 acc_any_reg, acc_any_next;

   // Output and sequence-check state; digit_reg doubles as the previous
   // valid digit because it only ever changes on a valid accept.
   logic [3:0] digit_reg, digit_next;
   logic       digit_valid_reg, digit_valid_next;
   logic       blank_reg, blank_next;
   logic       prev_valid_reg, prev_valid_next;
   logic       strobe_reg, strobe_next;
   logic       pattern_err_reg, pattern_err_next;
   logic       seq_err_reg, seq_err_next;
   logic [7:0] wrap_count_reg, wrap_count_next;

   // Decode of the current candidate.
   logic [3:0] dec_digit;
   logic       dec_valid;
   logic       accept;

   seg7_pattern_decode u_decode (
      .pattern (cand_reg),
      .digit   (dec_digit),
      .valid   (dec_valid)
   );

   // Two-flop synchroniser for the asynchronous segment lines.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_reg <= '0;
         s2_reg <= '0;
      end else begin
         s1_reg <= seg_in;
         s2_reg <= s1_reg;
      end
   end

   // State register for candidate tracking, accepted pattern and outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_reg        <= '0;
         cnt_reg         <= '0;
         state_reg       <= EMPTY;
         acc_pat_reg     <= '0;
         acc_any_reg     <= 1'b0;
         digit_reg       <= '0;
         digit_valid_reg <= 1'b0;
         blank_reg       <= 1'b0;
         prev_valid_reg  <= 1'b0;
         strobe_reg      <= 1'b0;
         pattern_err_reg <= 1'b0;
         seq_err_reg     <= 1'b0;
         wrap_count_reg  <= '0;
      end else begin
         cand_reg        <= cand_next;
         cnt_reg         <= cnt_next;
         state_reg       <= state_next;
         acc_pat_reg     <= acc_pat_next;
         acc_any_reg     <= acc_any_next;
         digit_reg       <= digit_next;
         digit_valid_reg <= digit_valid_next;
         blank_reg       <= blank_next;
         prev_valid_reg  <= prev_valid_next;
         strobe_reg      <= strobe_next;
         pattern_err_reg <= pattern_err_next;
         seq_err_reg     <= seq_err_next;
         wrap_count_reg  <= wrap_count_next;
      end
   end

   // Next-state: debounce the candidate, then act on accepted changes.
   always_comb begin
      cand_next        = cand_reg;
      cnt_next         = cnt_reg;
      state_next       = state_reg;
      acc_pat_next     = acc_pat_reg;
      acc_any_next     = acc_any_reg;
      digit_next       = digit_reg;
      digit_valid_next = digit_valid_reg;
      blank_next       = blank_reg;
      prev_valid_next  = prev_valid_reg;
      strobe_next      = 1'b0;
      pattern_err_next = 1'b0;
      seq_err_next     = 1'b0;
      wrap_count_next  = wrap_count_reg;
      accept           = 1'b0;

      // Any change of the synchronised sample restarts the count, whatever
      // the current state.
      if (s2_reg != cand_reg) begin
         cand_next  = s2_reg;
         cnt_next   = 8'd0;
         state_next = SETTLING;
      end else if (state_reg == SETTLING) begin
         if (cnt_reg == CNT_LAST) begin
            state_next = LOCKED;
            accept     = 1'b1;
         end else begin
            cnt_next = cnt_reg + 8'd1;
         end
      end

      // Re-accepting the already accepted pattern (glitch that returned)
      // leaves every output untouched.
      if (accept && (!acc_any_reg || (cand_reg != acc_pat_reg))) begin
         acc_pat_next = cand_reg;
         acc_any_next = 1'b1;
         if (dec_valid) begin
            if (prev_valid_reg) begin
               if ((dec_digit != next_in_seq(digit_reg, WRAP_DIGIT)) ||
                   (dec_digit > WRAP_DIGIT)) begin
                  seq_err_next = 1'b1;
               end
               if ((digit_reg == WRAP_DIGIT) && (dec_digit == 4'd0)) begin
                  wrap_count_next = wrap_count_reg + 8'd1;
               end
            end
            digit_next       = dec_digit;
            digit_valid_next = 1'b1;
            blank_next       = 1'b0;
            prev_valid_next  = 1'b1;
            strobe_next      = 1'b1;
         end else if (cand_reg == SEG_BLANK) begin
            blank_next       = 1'b1;
            digit_valid_next = 1'b0;
            prev_valid_next  = 1'b0;
         end else begin
            pattern_err_next = 1'b1;
            digit_valid_next = 1'b0;
            blank_next       = 1'b0;
            prev_valid_next  = 1'b0;
         end
      end
   end

   assign digit        = digit_reg;
   assign digit_valid  = digit_valid_reg;
   assign digit_strobe = strobe_reg;
   assign blank        = blank_reg;
   assign pattern_err  = pattern_err_reg;
   assign seq_err      = seq_err_reg;
   assign wrap_count   = wrap_count_reg;

endmodule
